// File: rtl/alu_pkg.sv
// Shared opcode, width and FSM-state definitions for the ALU command sequencer.
package alu_pkg;

    localparam int unsigned OPND_W = 4;
    localparam int unsigned OPC_W  = 3;

    localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
    localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
    localparam logic [OPC_W-1:0] OP_AND = 3'b010;
    localparam logic [OPC_W-1:0] OP_OR  = 3'b011;
    localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
    localparam logic [OPC_W-1:0] OP_NOT = 3'b101;
    localparam logic [OPC_W-1:0] OP_INC = 3'b110;
    localparam logic [OPC_W-1:0] OP_DEC = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    typedef struct packed {
        logic [OPC_W-1:0]  sel;
        logic [OPND_W-1:0] a;
        logic [OPND_W-1:0] b;
    } alu_cmd_t;

    localparam int unsigned CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU; carry is carry-out for ADD/INC and borrow for SUB/DEC.
module alu_4bit
    import alu_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic [OPC_W-1:0]  sel,
    output logic [OPND_W-1:0] result_c,
    output logic              carry_c,
    output logic              zero_c
);

    logic [OPND_W:0] sum_c;

    always_comb begin
        sum_c = '0;
        case (sel)
            OP_ADD:  sum_c = {1'b0, a} + {1'b0, b};
            OP_SUB:  sum_c = {1'b0, a} - {1'b0, b};
            OP_AND:  sum_c = {1'b0, a & b};
            OP_OR:   sum_c = {1'b0, a | b};
            OP_XOR:  sum_c = {1'b0, a ^ b};
            OP_NOT:  sum_c = {1'b0, ~a};
            OP_INC:  sum_c = {1'b0, a} + (OPND_W+1)'(1);
            default: sum_c = {1'b0, a} - (OPND_W+1)'(1);
        endcase
    end

    assign result_c = sum_c[OPND_W-1:0];
    assign carry_c  = sum_c[OPND_W];
    assign zero_c   = (sum_c[OPND_W-1:0] == '0);

endmodule

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO for ALU commands; DEPTH must be a power of two so pointers wrap naturally.
module alu_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d, empty_q, empty_d;
    logic             do_push_c, do_pop_c;

    assign do_push_c = push && !full_q;
    assign do_pop_c  = pop && !empty_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_c) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push_c, do_pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: entries are only read while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to an external ALU and holds each response
// until accepted. Define ALU_CMD_SEQ_STATS_EN to add the saturating op_count output.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    input  logic [OPC_W-1:0]  in_sel,
    output logic [OPND_W-1:0] alu_a,
    output logic [OPND_W-1:0] alu_b,
    output logic [OPC_W-1:0]  alu_sel,
    input  logic [OPND_W-1:0] alu_result,
    input  logic              alu_carry,
    input  logic              alu_zero,
`ifdef ALU_CMD_SEQ_STATS_EN
    output logic [7:0]        op_count,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OPND_W-1:0] out_result,
    output logic              out_carry,
    output logic              out_zero
);

    logic [1:0]        state_q, state_d;
    logic [OPND_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [OPC_W-1:0]  alu_sel_q, alu_sel_d;
    logic              out_valid_q, out_valid_d;
    logic [OPND_W-1:0] out_result_q, out_result_d;
    logic              out_carry_q, out_carry_d, out_zero_q, out_zero_d;
    logic              fifo_full, fifo_empty, pop_c;
    logic [CMD_W-1:0]  fifo_rdata;
    alu_cmd_t          wcmd_c, head_c;

    assign wcmd_c = '{sel: in_sel, a: in_a, b: in_b};
    assign head_c = alu_cmd_t'(fifo_rdata);

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .wdata (wcmd_c),
        .pop   (pop_c),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Issue/capture/hold sequencing; every pop loads the ALU operand registers.
    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_carry_d  = out_carry_q;
        out_zero_d   = out_zero_q;
        pop_c        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c     = 1'b1;
                    alu_a_d   = head_c.a;
                    alu_b_d   = head_c.b;
                    alu_sel_d = head_c.sel;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                out_result_d = alu_result;
                out_carry_d  = alu_carry;
                out_zero_d   = alu_zero;
                out_valid_d  = 1'b1;
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        pop_c     = 1'b1;
                        alu_a_d   = head_c.a;
                        alu_b_d   = head_c.b;
                        alu_sel_d = head_c.sel;
                        state_d   = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_carry_q  <= 1'b0;
            out_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_carry_q  <= out_carry_d;
            out_zero_q   <= out_zero_d;
        end
    end

`ifdef ALU_CMD_SEQ_STATS_EN
    logic [7:0] op_count_q, op_count_d;

    // Saturating count of accepted responses.
    always_comb begin
        op_count_d = op_count_q;
        if (out_valid_q && out_ready && (op_count_q != 8'hFF)) begin
            op_count_d = op_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

    assign in_ready   = !fifo_full;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_carry  = out_carry_q;
    assign out_zero   = out_zero_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer driving alu_4bit; expected values are hand-computed.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [OPND_W-1:0] in_a, in_b;
    logic [OPC_W-1:0]  in_sel;
    logic [OPND_W-1:0] alu_a, alu_b;
    logic [OPC_W-1:0]  alu_sel;
    logic [OPND_W-1:0] alu_result;
    logic              alu_carry, alu_zero;
    logic              out_valid, out_ready;
    logic [OPND_W-1:0] out_result;
    logic              out_carry, out_zero;
`ifdef ALU_CMD_SEQ_STATS_EN
    logic [7:0]        op_count;
`endif

    int checks = 0;
    int errors = 0;

    alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sel     (in_sel),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
`ifdef ALU_CMD_SEQ_STATS_EN
        .op_count   (op_count),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_carry  (out_carry),
        .out_zero   (out_zero)
    );

    alu_4bit u_alu (
        .a        (alu_a),
        .b        (alu_b),
        .sel      (alu_sel),
        .result_c (alu_result),
        .carry_c  (alu_carry),
        .zero_c   (alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [OPC_W-1:0]  ops [4];
        logic [OPND_W-1:0] exp_res [5];
        logic              exp_c [5];
        logic              exp_z [5];
        int n, last, seen;

        ops     = '{OP_ADD, OP_SUB, OP_AND, OP_OR};
        exp_res = '{4'h0, 4'h8, 4'h2, 4'h1, 4'h7};
        exp_c   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_z   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_regs", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        chk("rst_out_regs", 32'({out_result, out_carry, out_zero}), 32'd0);
`ifdef ALU_CMD_SEQ_STATS_EN
        chk("rst_op_count", 32'(op_count), 32'd0);
`endif
        @(negedge clk);
        chk("idle_no_valid", 32'(out_valid), 32'd0);

        // Single ADD 5+3 with consumer ready: out_valid two edges after accept.
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'h5; in_b = 4'h3; in_sel = OP_ADD;
        @(negedge clk);
        in_valid = 1'b0;
        chk("lat_e0_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_e1_valid", 32'(out_valid), 32'd0);
        chk("issue_alu_regs", 32'({alu_a, alu_b, alu_sel}), 32'({4'h5, 4'h3, OP_ADD}));
        @(negedge clk);
        chk("lat_e2_valid", 32'(out_valid), 32'd1);
        chk("add_resp", 32'({out_result, out_carry, out_zero}), 32'({4'h8, 1'b0, 1'b0}));
        @(negedge clk);
        chk("add_consumed", 32'(out_valid), 32'd0);
        chk("alu_retained", 32'({alu_a, alu_b, alu_sel}), 32'({4'h5, 4'h3, OP_ADD}));

        // 15+1 wraps to zero with carry; held stable while consumer stalls.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'hF; in_b = 4'h1; in_sel = OP_ADD;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_resp", 32'({out_valid, out_result, out_carry, out_zero}), 32'(7'b1_0000_1_1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("wrap_hold", 32'({out_valid, out_result, out_carry, out_zero}), 32'(7'b1_0000_1_1));
        end

        // Fill the buffer behind the held response, then verify back-pressure.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 4'h5; in_b = 4'h3; in_sel = ops[i];
            chk("fill_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("full_not_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_a = 4'h9; in_b = 4'h9; in_sel = OP_XOR;
        repeat (3) @(negedge clk);
        chk("fifth_held_off", 32'(in_ready), 32'd0);
        chk("hold_while_full", 32'({out_valid, out_result, out_carry, out_zero}), 32'(7'b1_0000_1_1));
        in_valid = 1'b0;

        // Drain: responses in command order, one every two cycles.
        out_ready = 1'b1;
        n = 0;
        last = 0;
        for (int cyc = 0; cyc < 40 && n < 5; cyc++) begin
            if (out_valid) begin
                chk("drain_resp", 32'({out_result, out_carry, out_zero}),
                    32'({exp_res[n], exp_c[n], exp_z[n]}));
                if (n > 0) chk("drain_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                n++;
            end
            @(negedge clk);
        end
        chk("drain_count", 32'(n), 32'd5);
        repeat (3) @(negedge clk);
        chk("drain_no_extra", 32'(out_valid), 32'd0);
        chk("drain_ready", 32'(in_ready), 32'd1);

        // Reset mid-ISSUE with two commands buffered and a same-cycle push.
        out_ready = 1'b0;
        in_valid = 1'b1; in_a = 4'h7; in_b = 4'h0; in_sel = OP_INC;
        @(negedge clk);
        in_a = 4'h0; in_sel = OP_DEC;
        @(negedge clk);
        chk("pre_rst_issue", 32'(alu_sel), 32'(OP_INC));
        rst = 1'b1;
        in_a = 4'h3; in_b = 4'h3; in_sel = OP_ADD;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        chk("mid_rst_out", 32'({out_result, out_carry, out_zero}), 32'd0);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("post_rst_silent", 32'(seen), 32'd0);

`ifdef ALU_CMD_SEQ_STATS_EN
        // Saturating response counter across 300 handshakes.
        chk("stats_start", 32'(op_count), 32'd0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'h1; in_b = 4'h1; in_sel = OP_ADD;
        n = 0;
        for (int cyc = 0; cyc < 2000 && n < 300; cyc++) begin
            if (out_valid && out_ready) begin
                if (n == 100) chk("op_count_100", 32'(op_count), 32'd100);
                n++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("stats_handshakes", 32'(n), 32'd300);
        chk("op_count_sat", 32'(op_count), 32'd255);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("op_count_rst", 32'(op_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, command buffer entries (power of two, >=2).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  command present on in_a/in_b/in_sel.
REQ-005 in_ready  output  1  command buffer can accept (not full).
REQ-006 in_a, in_b  input  4 each  operands.
REQ-007 in_sel  input  3  ALU opcode (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 INC, 111 DEC).
REQ-008 alu_a, alu_b  output  4 each  registered operands driven to the downstream ALU.
REQ-009 alu_sel  output  3  registered opcode driven to the ALU.
REQ-010 alu_result  input  4; alu_carry, alu_zero  input  1 each: combinational ALU outputs.
REQ-011 out_valid  output  1  response held on out_result/out_carry/out_zero.
REQ-012 out_ready  input  1  consumer accepts response.
REQ-013 out_result  output  4; out_carry, out_zero  output  1 each: captured ALU outputs.

Function
REQ-014 Command accepted on any edge where in_valid and in_ready are high; written to FIFO tail.
REQ-015 in_ready SHALL equal not-full; no push while full, no bypass around FIFO when empty.
REQ-016 FSM states: IDLE, ISSUE, HOLD.
REQ-017 IDLE: FIFO non-empty -> pop head into alu_a/alu_b/alu_sel, go ISSUE; else stay.
REQ-018 ISSUE (exactly one cycle): capture alu_result/carry/zero into out regs, set out_valid, go HOLD.
REQ-019 HOLD: out_valid and out fields SHALL stay stable until out_ready; on out_ready with FIFO non-empty pop next command and go ISSUE, else clear out_valid and go IDLE.
REQ-020 Latency: command accepted at edge E0 into empty idle block -> out_valid high after E0+2.
REQ-021 Peak throughput one response per 2 cycles with out_ready held high.
REQ-022 Simultaneous push and pop in one cycle SHALL be supported; occupancy unchanged.
REQ-023 Pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH.
REQ-024 Responses SHALL emerge in command order; no command dropped or duplicated.
REQ-025 alu_* outputs retain last issued values while IDLE/HOLD.

Reset
REQ-026 rst high at an edge: FIFO emptied, state IDLE, out_valid 0, out_result/carry/zero 0, alu_a/alu_b/alu_sel 0, in_ready 1 from following cycle.
REQ-027 Reset mid-operation SHALL discard buffered commands and any held response without emitting it.
REQ-028 Reset overrides a same-cycle push or out handshake.

Configuration
REQ-029 Macro ALU_CMD_SEQ_STATS_EN defined: extra output op_count (8-bit) increments on each out handshake, saturates at 255, cleared by rst.
REQ-030 Macro undefined: op_count port and counter absent; all other behaviour identical.

Structure
REQ-031 Shared package alu_pkg holds opcode constants (ADD..DEC), operand width (4), opcode width (3), FSM state encodings.
REQ-032 One sub-module alu_cmd_fifo (parameterised synchronous FIFO, 11-bit entries) instantiated once; FSM and output regs in top.

Verification
REQ-033 Bench instantiates alu_cmd_sequencer driving alu_4bit; checks each response against a reference model.
REQ-034 Push A=0101,B=0011,sel=000, out_ready=1 -> out_valid 2 cycles after accept, out_result=1000, carry=0, zero=0.
REQ-035 Push 4 commands back-to-back with out_ready=0 -> in_ready low after 4th; 5th held off; release out_ready -> 4 responses in order (ADD 1000, SUB 0010, AND 0001, OR 0111 for A=5,B=3).
REQ-036 A=1111,B=0001,sel=000 -> out_result=0000, carry=1, zero=1; held stable 5 cycles under out_ready=0.
REQ-037 Fill 2 commands, assert rst for 1 cycle mid-ISSUE -> out_valid 0, in_ready 1, no response emitted afterwards.
REQ-038 With ALU_CMD_SEQ_STATS_EN: 300 handshakes -> op_count=255; rst -> 0.
